// File: rtl/paddsb_acc_seq_pkg.sv
// Shared definitions for the PADDSB accumulate sequencer: lane geometry,
// saturation limits and FSM state encoding.
package paddsb_acc_seq_pkg;

    localparam int unsigned NUM_LANES = 4;
    localparam int unsigned LANE_W    = 4;
    localparam int unsigned DATA_W    = NUM_LANES * LANE_W;

    localparam logic [LANE_W-1:0] SAT_POS = 4'h7;
    localparam logic [LANE_W-1:0] SAT_NEG = 4'h8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/paddsb_acc_seq_lane.sv
// Single signed 4-bit lane adder that clamps to +7/-8 on overflow.
module padd_sat_lane
    import paddsb_acc_seq_pkg::*;
(
    input  logic [LANE_W-1:0] a_i,
    input  logic [LANE_W-1:0] b_i,
    output logic [LANE_W-1:0] sum_o,
    output logic              ovfl_o
);

    logic [LANE_W-1:0] raw;
    logic              ovf;

    always_comb begin
        raw = a_i + b_i;
        // Overflow only possible when both operands share a sign.
        ovf = (a_i[LANE_W-1] == b_i[LANE_W-1]) && (raw[LANE_W-1] != a_i[LANE_W-1]);
        sum_o  = ovf ? (a_i[LANE_W-1] ? SAT_NEG : SAT_POS) : raw;
        ovfl_o = ovf;
    end

endmodule

// File: rtl/paddsb_acc_seq.sv
// Multi-cycle reduction engine: folds a commanded number of packed-nibble
// beats into an accumulator with per-lane saturation and sticky flags.
module paddsb_acc_seq
    import paddsb_acc_seq_pkg::*;
#(
    parameter int unsigned CNT_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [15:0]       init_val,
    input  logic [CNT_W-1:0]  count,
    input  logic              in_valid,
    input  logic [15:0]       in_data,
    output logic              in_ready,
    output logic              busy,
    output logic              done,
    output logic [15:0]       result,
    output logic [3:0]        sat_flags,
    output logic              sat_any
);

    state_e                  state_q;
    logic [DATA_W-1:0]       acc_q;
    logic [DATA_W-1:0]       acc_d;
    logic [NUM_LANES-1:0]    sat_q;
    logic [NUM_LANES-1:0]    ovfl_d;
    logic [CNT_W-1:0]        rem_q;
    logic                    done_q;
    logic                    busy_q;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        padd_sat_lane u_lane (
            .a_i    (acc_q[g*LANE_W +: LANE_W]),
            .b_i    (in_data[g*LANE_W +: LANE_W]),
            .sum_o  (acc_d[g*LANE_W +: LANE_W]),
            .ovfl_o (ovfl_d[g])
        );
    end

    // busy_q/done_q are registered alongside the state so they track it exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            sat_q   <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        acc_q <= init_val;
                        rem_q <= count;
                        sat_q <= '0;
                        if (count == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ACCUM;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        acc_q <= acc_d;
                        sat_q <= sat_q | ovfl_d;
                        rem_q <= rem_q - 1'b1;
                        if (rem_q == CNT_W'(1)) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = busy_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = acc_q;
    assign sat_flags = sat_q;
    assign sat_any   = |sat_q;

endmodule

// File: tb/tb_paddsb_acc_seq.sv
// Directed self-checking bench for paddsb_acc_seq with hand-computed results.
module tb_paddsb_acc_seq;

    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [15:0]      init_val;
    logic [CNT_W-1:0] count;
    logic             in_valid;
    logic [15:0]      in_data;
    logic             in_ready;
    logic             busy;
    logic             done;
    logic [15:0]      result;
    logic [3:0]       sat_flags;
    logic             sat_any;

    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;

    always #5 clk = ~clk;

    paddsb_acc_seq #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .init_val  (init_val),
        .count     (count),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .sat_flags (sat_flags),
        .sat_any   (sat_any)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic do_start(input logic [15:0] init, input logic [CNT_W-1:0] cnt);
        @(negedge clk);
        start    = 1'b1;
        init_val = init;
        count    = cnt;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic send_beat(input logic [15:0] d);
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 16'h0000;
    endtask

    task automatic check_done(input string tag, input logic [15:0] exp_res, input logic [3:0] exp_sat);
        check({tag, "_done"}, {15'd0, done}, 16'd1);
        check({tag, "_result"}, result, exp_res);
        check({tag, "_sat"}, {12'd0, sat_flags}, {12'd0, exp_sat});
        check({tag, "_satany"}, {15'd0, sat_any}, {15'd0, |exp_sat});
        @(negedge clk);
        check({tag, "_done_clr"}, {15'd0, done}, 16'd0);
        check({tag, "_hold"}, result, exp_res);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; init_val = '0; count = '0;
        in_valid = 1'b0; in_data = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_result", result, 16'h0000);
        check("rst_sat", {12'd0, sat_flags}, 16'h0000);
        check("rst_done", {15'd0, done}, 16'd0);
        check("rst_busy", {15'd0, busy}, 16'd0);
        check("rst_ready", {15'd0, in_ready}, 16'd0);

        // Basic accumulate without saturation
        do_start(16'h1111, 4'd3);
        check("basic_busy", {15'd0, busy}, 16'd1);
        check("basic_ready", {15'd0, in_ready}, 16'd1);
        send_beat(16'h1111);
        send_beat(16'h1111);
        check("basic_nodone", {15'd0, done}, 16'd0);
        send_beat(16'hF0F0);
        check_done("basic", 16'h2323, 4'h0);

        // Positive saturation in every lane
        do_start(16'h0000, 4'd2);
        send_beat(16'h1234);
        send_beat(16'h7777);
        check_done("possat", 16'h7777, 4'hF);

        // Negative saturation in every lane
        do_start(16'h8888, 4'd1);
        send_beat(16'hFFFF);
        check_done("negsat", 16'h8888, 4'hF);

        // Mixed lanes: neg-sat, no-ovf (-8), plain, pos-sat
        do_start(16'h7F08, 4'd1);
        send_beat(16'h1F8F);
        check_done("mixed", 16'h7E88, 4'h9);

        // Zero count completes on the following cycle without ever accepting
        do_start(16'hABCD, 4'd0);
        check("zero_ready", {15'd0, in_ready}, 16'd0);
        check_done("zero", 16'hABCD, 4'h0);
        check("zero_ready_after", {15'd0, in_ready}, 16'd0);

        // start during ACCUM is ignored
        do_start(16'h0000, 4'd2);
        send_beat(16'h0011);
        check("ign_mid", result, 16'h0011);
        start = 1'b1; init_val = 16'hFFFF; count = 4'd1;
        @(negedge clk);
        start = 1'b0;
        check("ign_busy", {15'd0, busy}, 16'd1);
        check("ign_result", result, 16'h0011);
        check("ign_nodone", {15'd0, done}, 16'd0);
        send_beat(16'h0011);
        check("ign_done", {15'd0, done}, 16'd1);
        check("ign_final", result, 16'h0022);
        // start held during the DONE cycle must not be queued
        start = 1'b1; init_val = 16'h5555; count = 4'd3;
        @(negedge clk);
        start = 1'b0;
        check("doneign_busy", {15'd0, busy}, 16'd0);
        @(negedge clk);
        check("doneign_busy2", {15'd0, busy}, 16'd0);
        check("doneign_result", result, 16'h0022);

        // Gaps between beats
        do_start(16'h0000, 4'd4);
        for (int i = 0; i < 4; i++) begin
            logic [15:0] beat;
            logic [15:0] exp_acc;
            beat    = 16'h0001 << (4 * i);
            exp_acc = 16'h1111 >> (4 * (3 - i));
            for (int g = 0; g < 2; g++) begin
                @(negedge clk);
                check("gap_busy", {15'd0, busy}, 16'd1);
                check("gap_nodone", {15'd0, done}, 16'd0);
            end
            send_beat(beat);
            if (i < 3) begin
                check("gap_acc", result, exp_acc);
                check("gap_nodone_b", {15'd0, done}, 16'd0);
            end
        end
        check_done("gap", 16'h1111, 4'h0);

        // Reset after 2 of 4 beats, with a beat presented on the reset cycle
        do_start(16'h7777, 4'd4);
        send_beat(16'h7777);
        send_beat(16'h1111);
        rst = 1'b1; in_valid = 1'b1; in_data = 16'h1111;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        check("mrst_result", result, 16'h0000);
        check("mrst_sat", {12'd0, sat_flags}, 16'h0000);
        check("mrst_busy", {15'd0, busy}, 16'd0);
        check("mrst_ready", {15'd0, in_ready}, 16'd0);
        for (int i = 0; i < 4; i++) begin
            check("mrst_nodone", {15'd0, done}, 16'd0);
            @(negedge clk);
        end
        do_start(16'h0000, 4'd1);
        send_beat(16'h0123);
        check_done("post_rst", 16'h0123, 4'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
